// File: rtl/my_debounce.sv
// Four-state debouncer with registered level, rise/fall pulses and a saturating event counter.
// The event counter is built only when MY_DEBOUNCE_EVT_CNT_EN is defined; otherwise evt_cnt is tied to 0.
module my_debounce #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             cnt_clr,
    output logic             out,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] evt_cnt
);
    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] QMAX = QW'(STABLE_CYCLES);
    localparam logic [QW-1:0] QONE = QW'(1);

    typedef enum logic [1:0] {
        LOW,
        QUAL_HIGH,
        HIGH,
        QUAL_LOW
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_qcnt;
    logic          r_out;
    logic          r_rise;
    logic          r_fall;
    logic [QW-1:0] w_qnext;

    assign w_qnext = r_qcnt + QONE;

    // The counter holds the number of qualifying samples seen so far and stops at STABLE_CYCLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOW;
            r_qcnt  <= '0;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LOW: begin
                    if (in) begin
                        if (STABLE_CYCLES == 1) begin
                            r_state <= HIGH;
                            r_qcnt  <= '0;
                            r_out   <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_state <= QUAL_HIGH;
                            r_qcnt  <= QONE;
                        end
                    end else begin
                        r_qcnt <= '0;
                    end
                end
                QUAL_HIGH: begin
                    if (!in) begin
                        r_state <= LOW;
                        r_qcnt  <= '0;
                    end else if (w_qnext == QMAX) begin
                        r_state <= HIGH;
                        r_qcnt  <= '0;
                        r_out   <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_qcnt <= w_qnext;
                    end
                end
                HIGH: begin
                    if (!in) begin
                        if (STABLE_CYCLES == 1) begin
                            r_state <= LOW;
                            r_qcnt  <= '0;
                            r_out   <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_state <= QUAL_LOW;
                            r_qcnt  <= QONE;
                        end
                    end else begin
                        r_qcnt <= '0;
                    end
                end
                QUAL_LOW: begin
                    if (in) begin
                        r_state <= HIGH;
                        r_qcnt  <= '0;
                    end else if (w_qnext == QMAX) begin
                        r_state <= LOW;
                        r_qcnt  <= '0;
                        r_out   <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_qcnt <= w_qnext;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_qcnt  <= '0;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign rise = r_rise;
    assign fall = r_fall;

`ifdef MY_DEBOUNCE_EVT_CNT_EN
    logic [CNT_W-1:0] r_evt_cnt;

    // Counts the cycles where rise reads 1; a clear in the same cycle keeps that event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_cnt <= '0;
        end else if (cnt_clr) begin
            r_evt_cnt <= r_rise ? CNT_W'(1) : '0;
        end else if (r_rise && (r_evt_cnt != '1)) begin
            r_evt_cnt <= r_evt_cnt + CNT_W'(1);
        end
    end

    assign evt_cnt = r_evt_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign evt_cnt          = '0;
`endif

endmodule

// File: tb/tb_my_debounce.sv
// Self-checking bench for my_debounce: three instances (STABLE_CYCLES 4/4/1) share one stimulus stream.
// Expected evt_cnt follows MY_DEBOUNCE_EVT_CNT_EN; a scoreboard queue backs a vector table and corner sequences.
module tb_my_debounce;

`ifdef MY_DEBOUNCE_EVT_CNT_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif
    localparam int E1 = EVT_EN ? 1 : 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in;
    logic        cnt_clr;
    logic        out4, rise4, fall4;
    logic [15:0] evt4;
    logic        out3, rise3, fall3;
    logic [2:0]  evt3;
    logic        out1, rise1, fall1;
    logic [7:0]  evt1;

    my_debounce #(.STABLE_CYCLES(4), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .in(in), .cnt_clr(cnt_clr),
        .out(out4), .rise(rise4), .fall(fall4), .evt_cnt(evt4));
    my_debounce #(.STABLE_CYCLES(4), .CNT_W(3)) u3 (
        .clk(clk), .rst(rst), .in(in), .cnt_clr(cnt_clr),
        .out(out3), .rise(rise3), .fall(fall3), .evt_cnt(evt3));
    my_debounce #(.STABLE_CYCLES(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in(in), .cnt_clr(cnt_clr),
        .out(out1), .rise(rise1), .fall(fall1), .evt_cnt(evt1));

    typedef struct {
        int s; int evtMax; bit out; int run; bit rise; bit fall; int evt;
    } mdl_t;
    typedef struct {
        int inst; bit out; bit rise; bit fall; int evt;
    } exp_t;
    typedef struct {
        bit rst; bit in; bit clr; bit out; bit rise; bit fall; int evt;
    } vec_t;

    mdl_t  m[3];
    exp_t  sb[$];
    vec_t  tbl[$];
    int    nTests = 0;
    int    nFail  = 0;
    string names[3] = '{"u4", "u3", "u1"};

    // Reference: count consecutive samples that differ from the current output level.
    function automatic mdl_t stepModel(mdl_t cur, bit r, bit i, bit c);
        mdl_t n = cur;
        if (r) begin
            n.out = 1'b0; n.run = 0; n.rise = 1'b0; n.fall = 1'b0; n.evt = 0;
            return n;
        end
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (EVT_EN) begin
            if (c) n.evt = cur.rise ? 1 : 0;
            else if (cur.rise && cur.evt < cur.evtMax) n.evt = cur.evt + 1;
        end
        if (i != cur.out) begin
            n.run = cur.run + 1;
            if (n.run >= cur.s) begin
                n.out = i; n.run = 0; n.rise = i; n.fall = !i;
            end
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    task automatic checkVal(string name, int act, int req);
        nTests++;
        if (act != req) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        bit o, r, f;
        int ev;
        repeat (3) begin
            if (sb.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
                return;
            end
            e = sb.pop_front();
            case (e.inst)
                0:       begin o = out4; r = rise4; f = fall4; ev = int'(evt4); end
                1:       begin o = out3; r = rise3; f = fall3; ev = int'(evt3); end
                default: begin o = out1; r = rise1; f = fall1; ev = int'(evt1); end
            endcase
            checkVal({names[e.inst], ".out"}, int'(o), int'(e.out));
            checkVal({names[e.inst], ".rise"}, int'(r), int'(e.rise));
            checkVal({names[e.inst], ".fall"}, int'(f), int'(e.fall));
            checkVal({names[e.inst], ".evt_cnt"}, ev, e.evt);
            checkVal({names[e.inst], ".rise&fall"}, int'(r & f), 0);
        end
    endtask

    task automatic applyStimulus(bit r, bit i, bit c);
        exp_t e;
        rst     = r;
        in      = i;
        cnt_clr = c;
        for (int k = 0; k < 3; k++) begin
            m[k] = stepModel(m[k], r, i, c);
            e = '{inst: k, out: m[k].out, rise: m[k].rise, fall: m[k].fall, evt: m[k].evt};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        bit prevIn;
        bit lvl;
        rst = 1'b1; in = 1'b0; cnt_clr = 1'b0;
        m[0] = '{s: 4, evtMax: 65535, out: 0, run: 0, rise: 0, fall: 0, evt: 0};
        m[1] = '{s: 4, evtMax: 7,     out: 0, run: 0, rise: 0, fall: 0, evt: 0};
        m[2] = '{s: 1, evtMax: 255,   out: 0, run: 0, rise: 0, fall: 0, evt: 0};

        // Vectors for u4: rise on the 4th high sample, fall on the 4th low sample, clear, aborted qualification.
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 0, E1});
        tbl.push_back('{0, 0, 0, 1, 0, 0, E1});
        tbl.push_back('{0, 0, 0, 1, 0, 0, E1});
        tbl.push_back('{0, 0, 0, 1, 0, 0, E1});
        tbl.push_back('{0, 0, 0, 0, 0, 1, E1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, E1});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0});

        for (int v = 0; v < tbl.size(); v++) begin
            applyStimulus(tbl[v].rst, tbl[v].in, tbl[v].clr);
            checkVal($sformatf("tbl[%0d].out", v), int'(out4), int'(tbl[v].out));
            checkVal($sformatf("tbl[%0d].rise", v), int'(rise4), int'(tbl[v].rise));
            checkVal($sformatf("tbl[%0d].fall", v), int'(fall4), int'(tbl[v].fall));
            checkVal($sformatf("tbl[%0d].evt", v), int'(evt4), tbl[v].evt);
        end

        // Glitch train 1,1,1,0 never qualifies with four-cycle debouncing.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 40; g++) begin
            applyStimulus(1'b0, (g % 4) != 3, 1'b0);
            checkVal("glitch.out", int'(out4), 0);
            checkVal("glitch.rise", int'(rise4), 0);
        end
        checkVal("glitch.evt", int'(evt4), 0);

        // Reset during qualification at count 3, then a clean qualification from scratch.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkVal("rstqual.out", int'(out4), 0);
        checkVal("rstqual.rise", int'(rise4), 0);
        checkVal("rstqual.fall", int'(fall4), 0);
        for (int e = 1; e <= 4; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkVal($sformatf("rstrel[%0d].out", e), int'(out4), (e == 4) ? 1 : 0);
            checkVal($sformatf("rstrel[%0d].rise", e), int'(rise4), (e == 4) ? 1 : 0);
        end

        // Nine debounced rises saturate the 3-bit counter; a clear alongside the tenth rise keeps it.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 9; n++) begin
            repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
            repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkVal("sat.evt3", int'(evt3), EVT_EN ? 7 : 0);
        checkVal("sat.evt4", int'(evt4), EVT_EN ? 9 : 0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        checkVal("rise10.rise3", int'(rise3), 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkVal("clr10.evt3", int'(evt3), E1);
        checkVal("clr10.evt4", int'(evt4), E1);

        // Single-cycle debouncing follows the input one edge later.
        applyStimulus(1'b1, 1'b0, 1'b0);
        prevIn = 1'b0;
        for (int t = 0; t < 16; t++) begin
            lvl = ((t >> 1) & 1) != 0;
            applyStimulus(1'b0, lvl, 1'b0);
            checkVal($sformatf("s1[%0d].out", t), int'(out1), int'(lvl));
            checkVal($sformatf("s1[%0d].rise", t), int'(rise1), int'(lvl && !prevIn));
            checkVal($sformatf("s1[%0d].fall", t), int'(fall1), int'(!lvl && prevIn));
            prevIn = lvl;
        end
        checkVal("s1.evt1", int'(evt1), EVT_EN ? 4 : 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/my_debounce.md
MY_DEBOUNCE -- requirements
Module: my_debounce

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 16: consecutive samples of a new level required before the output changes; legal range 1..65535.
REQ-002 SHALL provide parameter CNT_W, default 16: width of the rising-edge event counter.
REQ-003 SHALL provide port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL provide port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL provide port in, input, 1: level already synchronized to clk by the upstream two-flop stage; no further synchronization inside.
REQ-006 SHALL provide port cnt_clr, input, 1: synchronous clear of the event counter.
REQ-007 SHALL provide port out, output, 1: debounced level, registered.
REQ-008 SHALL provide port rise, output, 1: one-cycle pulse on a debounced 0->1 transition.
REQ-009 SHALL provide port fall, output, 1: one-cycle pulse on a debounced 1->0 transition.
REQ-010 SHALL provide port evt_cnt, output, CNT_W: count of debounced rising edges.

Function
REQ-011 SHALL implement four states: LOW, QUAL_HIGH, HIGH, QUAL_LOW; out is 0 in LOW/QUAL_HIGH and 1 in HIGH/QUAL_LOW.
REQ-012 SHALL, in LOW with in=1, enter QUAL_HIGH and load the qualification counter with 1; in LOW with in=0, remain and hold counter at 0.
REQ-013 SHALL, in QUAL_HIGH with in=1, increment the counter; once in=1 has been sampled on STABLE_CYCLES consecutive edges, enter HIGH at that edge with counter cleared.
REQ-014 SHALL, in QUAL_HIGH with in=0 on any edge, return to LOW with counter cleared, and out SHALL remain 0.
REQ-015 SHALL mirror REQ-012..014 for HIGH/QUAL_LOW with in=0 as the qualifying level.
REQ-016 SHALL, when STABLE_CYCLES=1, go LOW->HIGH (or HIGH->LOW) directly on the first differing sample, without dwelling in a QUAL state.
REQ-017 SHALL size the qualification counter as clog2(STABLE_CYCLES+1) bits; the counter SHALL never exceed STABLE_CYCLES and SHALL never wrap.
REQ-018 SHALL give latency from the first sample of a new stable level to the out change of exactly STABLE_CYCLES clock edges (out updates on the Nth qualifying edge).
REQ-019 SHALL assert rise (fall) for exactly the first cycle in which out reads 1 (0) after a transition; rise and fall SHALL never be asserted together.
REQ-020 SHALL increment evt_cnt by one on each cycle in which rise is asserted, and saturate at all-ones (no wrap).
REQ-021 SHALL, when cnt_clr=1, load evt_cnt with 1 if rise is asserted that cycle, otherwise 0 (clear and event together count the event).
REQ-022 SHALL register all outputs; there SHALL be no combinational path from in to any output.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, force state LOW, qualification counter 0, out 0, rise 0, fall 0, and evt_cnt 0.
REQ-024 SHALL abandon a qualification in progress on reset without emitting a pulse; after rst deasserts with in=1 held, out SHALL rise after STABLE_CYCLES edges.
REQ-025 SHALL give rst priority over cnt_clr and all state transitions.

Configuration
REQ-026 SHALL compile the event counter only when macro MY_DEBOUNCE_EVT_CNT_EN is defined.
REQ-027 SHALL, without MY_DEBOUNCE_EVT_CNT_EN, tie evt_cnt to constant 0, ignore cnt_clr, and create no counter flops; out/rise/fall behaviour SHALL be identical in both builds.

Verification
REQ-028 SHALL cover STABLE_CYCLES=4, reset then in=1 held: out=1 and rise=1 on the 4th edge after in=1 is first sampled, rise=0 next cycle, evt_cnt=1.
REQ-029 SHALL cover STABLE_CYCLES=4, in glitch pattern 1,1,1,0 repeated 10 times: out stays 0, no rise, evt_cnt=0.
REQ-030 SHALL cover STABLE_CYCLES=4 from HIGH, in=0 for 4 samples: fall pulse one cycle with out=0, evt_cnt unchanged.
REQ-031 SHALL cover CNT_W=3 with 9 debounced rising edges: evt_cnt saturates at 7; cnt_clr coincident with the 10th rise yields evt_cnt=1.
REQ-032 SHALL cover rst asserted at qualification count 3 of 4: out=0, no pulses; after release with in=1, out rises 4 edges later.
REQ-033 SHALL cover STABLE_CYCLES=1 with in toggling every 2 cycles: out follows in delayed one edge, alternating rise/fall pulses; repeated with the macro undefined: evt_cnt=0 throughout.
